// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default sizing shared by the UART receiver and the future transmitter.
package uart_pkg;
    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int TICK_W = $clog2(DEF_OVERSAMPLE);
    localparam int BIT_W  = $clog2(DEF_DATA_BITS);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} rx_state_e;
endpackage

// File: rtl/uart_rx_oversample_if.sv
// uart_rx_oversample_if: receiver-to-host byte handshake plus status pulses.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_oversample_if #(parameter int DATA_BITS = uart_pkg::DEF_DATA_BITS);
    logic [DATA_BITS-1:0] rx_data;
    logic rx_valid, rx_ready, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
    modport master (output rx_data, rx_valid, frame_err, overrun, busy, parity_err, input rx_ready);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, busy, parity_err, output rx_ready);
`else
    modport master (output rx_data, rx_valid, frame_err, overrun, busy, input rx_ready);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, busy, output rx_ready);
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the idle-high serial line, resets to 1.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else sync_q <= {sync_q[0], d_i};
    end
    assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: oversampled UART receiver delivering bytes over a valid/ready handshake.
// Define UART_RX_PARITY_EN for an even-parity bit and the parity_err pulse.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic baud_tick,
    input  logic rx,
    uart_rx_oversample_if.master host
);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_e AFTER_DATA = PARITY;
`else
    localparam rx_state_e AFTER_DATA = STOP;
`endif
    rx_state_e state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic rx_s, centre, done, accept;

    uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .d_i(rx), .q_o(rx_s));

    assign centre = baud_tick && tick_q == TICK_W'(OVERSAMPLE-1);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d, perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = baud_tick ? tick_q + 1'b1 : tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done    = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: if (baud_tick && !rx_s) begin
                tick_d  = '0;
                state_d = START;
            end
            START: if (baud_tick && tick_q == TICK_W'(OVERSAMPLE/2-1)) begin
                tick_d  = '0;
                bit_d   = '0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (centre) begin
                tick_d  = '0;
                shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                bit_d   = bit_q + 1'b1;
                state_d = bit_q == BIT_W'(DATA_BITS-1) ? AFTER_DATA : DATA;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (centre) begin
                tick_d  = '0;
                par_d   = rx_s;
                state_d = STOP;
            end
`endif
            STOP: if (centre) begin
                tick_d  = '0;
                done    = rx_s;
                ferr_d  = !rx_s;
                state_d = rx_s ? IDLE : BRK;
            end
            BRK: if (baud_tick && rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A completed byte is dropped only when the previous one is still pending this cycle.
    always_comb begin
        accept  = valid_q && host.rx_ready;
        ovr_d   = done && valid_q && !accept;
        data_d  = done && !ovr_d ? shift_q : data_q;
        valid_d = done || (valid_q && !accept);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign perr_d = done && (^{shift_q, par_q});
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end
    assign host.parity_err = perr_q;
`endif

    assign host.rx_data   = data_q;
    assign host.rx_valid  = valid_q;
    assign host.frame_err = ferr_q;
    assign host.overrun   = ovr_q;
    assign host.busy      = state_q != IDLE;
endmodule
